// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its byte-stream consumers.
// Word/byte geometry plus the serializer's FSM state encoding.
package sync_fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int BYTE_W      = 8;
  localparam int BEATS       = FIFO_DATA_W / BYTE_W;
  localparam int BEAT_CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } ser_state_e;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from a one-cycle-latency FIFO read port and streams each
// word out as four valid/ready byte beats, MSB-first or LSB-first.
module fifo_byte_serializer
  import sync_fifo_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   drain_en,
  input  logic                   fifo_empty,
  input  logic [FIFO_DATA_W-1:0] fifo_rd_data,
  output logic                   fifo_rd_en,
  output logic [BYTE_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy
);

  ser_state_e             state;
  logic [FIFO_DATA_W-1:0] shift_reg;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic                   handshake;
  logic                   last_hs;
  logic                   pop_ok;
  logic [FIFO_DATA_W-1:0] shifted;

  function automatic logic [BYTE_W-1:0] lead_byte(input logic [FIFO_DATA_W-1:0] w);
    return MSB_FIRST ? w[FIFO_DATA_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

  assign handshake = out_valid & out_ready;
  assign last_hs   = (state == SEND) & handshake & (beat_cnt == BEAT_CNT_W'(BEATS - 1));
  assign shifted   = MSB_FIRST ? (shift_reg << BYTE_W) : (shift_reg >> BYTE_W);

  // A pop is only legal from IDLE or on the final handshake of a word, and is
  // gated by rst_n so the FIFO never sees a request while reset is held.
  assign pop_ok     = rst_n & drain_en & ~fifo_empty;
  assign fifo_rd_en = pop_ok & ((state == IDLE) | last_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        // Read data lands here, one cycle after the pop.
        WAIT: begin
          shift_reg <= fifo_rd_data;
          out_data  <= lead_byte(fifo_rd_data);
          out_valid <= 1'b1;
          out_last  <= (BEATS == 1);
          beat_cnt  <= '0;
          state     <= SEND;
        end
        SEND: begin
          if (handshake) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_hs) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= fifo_rd_en ? WAIT : IDLE;
              busy      <= fifo_rd_en;
            end else begin
              shift_reg <= shifted;
              out_data  <= lead_byte(shifted);
              out_last  <= (beat_cnt == BEAT_CNT_W'(BEATS - 2));
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench for fifo_byte_serializer: an MSB-first and an LSB-first
// instance, each fed by a behavioural one-cycle-latency FIFO.
module tb_fifo_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        m_empty;
  logic [31:0] m_rd_data = '0;
  logic        m_rd_en;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_busy;

  logic        l_drain = 1'b1;
  logic        l_ready = 1'b1;
  logic        l_empty;
  logic [31:0] l_rd_data = '0;
  logic        l_rd_en;
  logic [7:0]  l_data;
  logic        l_valid, l_last, l_busy;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [31:0] mq[$];
  logic [31:0] lq[$];
  logic [8:0]  mexp[$];
  logic [8:0]  lexp[$];
  int          acc_cyc[$];
  int          mcnt = 0;
  int          lcnt = 0;
  int          m_pops = 0;
  int          l_pops = 0;
  int          rd_err = 0;
  int          illegal_pops = 0;
  int          m_acc = 0;
  int          last_pop_cyc = 0;
  bit          m_await_first = 1'b1;
  bit          m_pop_pend = 1'b0;
  bit          l_pop_pend = 1'b0;
  bit          prev_stalled = 1'b0;
  logic [8:0]  prev_out = '0;

  always #5 clk = ~clk;

  assign m_empty = (mcnt == 0);
  assign l_empty = (lcnt == 0);

  fifo_byte_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .drain_en(drain_en), .fifo_empty(m_empty),
    .fifo_rd_data(m_rd_data), .fifo_rd_en(m_rd_en), .out_data(m_data),
    .out_valid(m_valid), .out_last(m_last), .out_ready(out_ready), .busy(m_busy)
  );

  fifo_byte_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .drain_en(l_drain), .fifo_empty(l_empty),
    .fifo_rd_data(l_rd_data), .fifo_rd_en(l_rd_en), .out_data(l_data),
    .out_valid(l_valid), .out_last(l_last), .out_ready(l_ready), .busy(l_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Loads a word into the chosen FIFO and queues its four expected beats.
  task automatic applyStimulus(input bit lsb, input logic [31:0] w);
    if (!lsb) begin
      mq.push_back(w);
      mcnt++;
      for (int i = 0; i < 4; i++) mexp.push_back({i == 3, w[31-8*i -: 8]});
    end else begin
      lq.push_back(w);
      lcnt++;
      for (int i = 0; i < 4; i++) lexp.push_back({i == 3, w[8*i +: 8]});
    end
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (n < 300 && !(mexp.size() == 0 && lexp.size() == 0 && !m_busy && !l_busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("[TB] FAIL %s: timeout with %0d bytes outstanding, expected 0", name,
               mexp.size() + lexp.size());
    end
    @(posedge clk);
    #1;
  endtask

  // FIFO models: read data registered one cycle after an accepted pop.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && m_pop_pend && mq.size() > 0) begin
      m_rd_data <= mq.pop_front();
      mcnt--;
    end
    if (rst_n && l_pop_pend && lq.size() > 0) begin
      l_rd_data <= lq.pop_front();
      lcnt--;
    end
  end

  // MSB-instance monitor: pop legality, stall stability, latency and bytes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stalled  = 1'b0;
      m_pop_pend    = 1'b0;
      m_await_first = 1'b1;
    end else begin
      m_pop_pend = m_rd_en && !m_empty;
      if (m_rd_en) begin
        m_pops++;
        last_pop_cyc = cyc;
        if (m_empty) rd_err++;
        if (m_busy && !(m_valid && out_ready && m_last)) illegal_pops++;
      end
      if (prev_stalled) begin
        checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("hold_data", {23'd0, m_last, m_data}, {23'd0, prev_out});
      end
      prev_stalled = 1'b0;
      if (m_valid) begin
        if (m_await_first) begin
          checkOutput("first_byte_latency", cyc - last_pop_cyc, 32'd2);
          m_await_first = 1'b0;
        end
        if (out_ready) begin
          if (mexp.size() == 0) begin
            checks++;
            $display("[TB] FAIL msb_byte: got unexpected byte 0x%0h, expected none", m_data);
          end else begin
            checkOutput("msb_byte", {23'd0, m_last, m_data}, {23'd0, mexp.pop_front()});
          end
          m_acc++;
          acc_cyc.push_back(cyc);
          if (m_last) m_await_first = 1'b1;
        end else begin
          prev_stalled = 1'b1;
          prev_out     = {m_last, m_data};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      l_pop_pend = 1'b0;
    end else begin
      l_pop_pend = l_rd_en && !l_empty;
      if (l_rd_en) begin
        l_pops++;
        if (l_empty) rd_err++;
      end
      if (l_valid && l_ready) begin
        if (lexp.size() == 0) begin
          checks++;
          $display("[TB] FAIL lsb_byte: got unexpected byte 0x%0h, expected none", l_data);
        end else begin
          checkOutput("lsb_byte", {23'd0, l_last, l_data}, {23'd0, lexp.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    logic [4:0] pat;

    // Reset state, with a word waiting so the pop gate on rst_n is exercised.
    applyStimulus(1'b0, 32'h11223344);
    applyStimulus(1'b1, 32'h11223344);
    drain_en  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_out_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_out_data", {24'd0, m_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, m_rd_en}, 32'd0);
    checkOutput("rst_rd_en_lsb", {31'd0, l_rd_en}, 32'd0);
    rst_n = 1'b1;
    waitDone("single_word");
    checkOutput("single_fifo_empty", mcnt, 32'd0);
    checkOutput("single_pops", m_pops, 32'd1);
    checkOutput("lsb_pops", l_pops, 32'd1);

    // Back-to-back words: one bubble per boundary gives a 13-cycle span.
    acc_cyc.delete();
    base = m_pops;
    applyStimulus(1'b0, 32'hA0A1A2A3);
    applyStimulus(1'b0, 32'hB0B1B2B3);
    applyStimulus(1'b0, 32'hC0C1C2C3);
    waitDone("back_to_back");
    checkOutput("b2b_pops", m_pops - base, 32'd3);
    checkOutput("b2b_beats", acc_cyc.size(), 32'd12);
    if (acc_cyc.size() == 12) checkOutput("b2b_span", acc_cyc[11] - acc_cyc[0], 32'd13);

    // Backpressure with out_ready cycling 1-0-0-1-0.
    base = m_pops;
    pat  = 5'b10010;
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'hDEADBEEF);
    n = 0;
    while (n < 100 && !(mexp.size() == 0 && !m_busy)) begin
      @(posedge clk);
      #1;
      out_ready = pat[4 - (n % 5)];
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("[TB] FAIL backpressure: timeout with %0d bytes outstanding, expected 0", mexp.size());
    end
    out_ready = 1'b1;
    checkOutput("bp_pops", m_pops - base, 32'd1);

    // Empty FIFO with drain enabled: nothing happens.
    base = m_pops;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("empty_pops", m_pops - base, 32'd0);
    checkOutput("empty_busy", {31'd0, m_busy}, 32'd0);

    // Drain disabled with data present: no pop.
    drain_en = 1'b0;
    applyStimulus(1'b0, 32'h0A0B0C0D);
    applyStimulus(1'b0, 32'h1A1B1C1D);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("nodrain_pops", m_pops - base, 32'd0);
    checkOutput("nodrain_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("nodrain_rd_en", {31'd0, m_rd_en}, 32'd0);

    // Drain dropped after beat 2: word finishes, second word stays queued.
    base = m_acc;
    drain_en = 1'b1;
    n = 0;
    while (n < 50 && m_acc < base + 2) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    drain_en = 1'b0;
    n = 0;
    while (n < 50 && !(mexp.size() == 4 && !m_busy)) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drain_stop_bytes_left", mexp.size(), 32'd4);
    checkOutput("drain_stop_fifo_count", mcnt, 32'd1);
    checkOutput("drain_stop_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("drain_stop_accepted", m_acc - base, 32'd4);
    drain_en = 1'b1;
    waitDone("drain_resume");

    // Reset mid-word while the first byte is stalled, then a fresh word.
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h01020304);
    n = 0;
    while (n < 20 && !m_valid) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pre_reset_byte", {24'd0, m_data}, 32'h01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("async_rst_data", {24'd0, m_data}, 32'd0);
    mexp.delete();
    mq.delete();
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h55667788);
    waitDone("post_reset");

    checkOutput("fifo_rd_err", rd_err, 32'd0);
    checkOutput("illegal_pops", illegal_pops, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_byte_serializer.md
# fifo_byte_serializer

Downstream consumer of the 32-bit synchronous FIFO. Pops one word at a time through the FIFO read port and emits it as four 8-bit beats on a valid/ready byte stream. Output order is programmable: MSB-first or LSB-first. The FIFO read port has one cycle of latency (data registered), and this block is built around that.

## Interface
- MSB_FIRST, 1: 1 = emit bits [31:24] first; 0 = emit bits [7:0] first.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- drain_en  in  1  permits new FIFO pops. Has no effect on a word already in flight.
- fifo_empty  in  1  FIFO empty flag, combinational from the FIFO pointers.
- fifo_rd_data  in  32  FIFO read data. Valid the cycle after fifo_rd_en is asserted with fifo_empty=0.
- fifo_rd_en  out  1  FIFO pop request, combinational.
- out_data  out  8  current byte, registered.
- out_valid  out  1  byte valid, registered.
- out_last  out  1  high with the 4th byte of each word.
- out_ready  in  1  sink accepts the byte when out_valid & out_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - fifo_rd_en = drain_en & ~fifo_empty.
  - If fifo_rd_en is high, go to WAIT.
- WAIT (one cycle only):
  - Capture fifo_rd_data into a 32-bit shift register.
  - Set beat counter to 0 and set out_valid.
  - Go to SEND.
- SEND:
  - out_data = shift register byte [31:24] when MSB_FIRST=1, else byte [7:0].
  - On each handshake, shift the register by 8 bits (left when MSB_FIRST=1, right otherwise) and increment the 2-bit beat counter.
  - out_last = (beat counter == 3).
  - Handshake on the last beat with drain_en & ~fifo_empty: fifo_rd_en=1 in that same cycle, out_valid drops, go to WAIT.
  - Handshake on the last beat otherwise: out_valid drops, go to IDLE.
- Handshake rules:
  - out_data, out_valid and out_last are held stable while out_valid & ~out_ready. Backpressure stalls for any number of cycles.
  - out_valid never depends combinationally on out_ready.
- fifo_rd_en is never asserted while fifo_empty=1, so the FIFO read-error flag must never fire.
- fifo_rd_en is never asserted in WAIT, or in SEND before the last handshake. At most one word is outstanding.
- drain_en deasserted mid-word: the current word completes all four beats, then the block returns to IDLE.
- Reset values:
  - State IDLE.
  - Shift register 0, beat counter 0.
  - out_data 0, out_valid 0, out_last 0, busy 0.
  - fifo_rd_en 0 while rst_n=0.
- Reset mid-word: the in-flight word is discarded. The FIFO is reset on the same rst_n.

## Timing
- Pop at cycle T (fifo_rd_en=1) → WAIT at T+1 → first byte valid at T+2.
- Full-speed throughput, out_ready held at 1: 4 beats per word plus 1 bubble (WAIT) = 5 cycles/word.
- Back-to-back pop: last beat accepted at cycle S with fifo_rd_en=1 at S → next word's first byte at S+2.
- fifo_empty is sampled combinationally in the pop cycle only. It is not re-checked in WAIT.

## Structure
- Shared package sync_fifo_pkg holds:
  - constants FIFO_DATA_W=32, BYTE_W=8, BEATS=FIFO_DATA_W/BYTE_W;
  - the FSM state enum {IDLE, WAIT, SEND}.
- Single module, no sub-module. Shift register, counter and FSM are together small enough.
- Integration: instantiate next to sync_fifo, sharing clk/rst_n. Connect fifo_empty, fifo_rd_en and fifo_rd_data directly.

## Test plan
- MSB-first single word: write 0x11223344, out_ready=1 → bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; out_last only on 0x44; FIFO ends empty.
- LSB-first (MSB_FIRST=0), same word → bytes 0x44, 0x33, 0x22, 0x11.
- Back-to-back: preload 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 → 12 bytes in order, exactly one bubble between words, fifo_rd_en pulses 3 times, fifo_rd_err never set.
- Backpressure: toggle out_ready 1-0-0-1-0-1… on word 0xDEADBEEF → out_data held while stalled; sequence DE, AD, BE, EF; no FIFO pop until the last handshake.
- Empty/drain_en:
  - FIFO empty → fifo_rd_en stays 0 and busy stays 0.
  - drain_en=0 with FIFO non-empty → no pop.
  - drain_en deasserted on beat 2 → word completes, then IDLE.
- Reset mid-word: assert rst_n=0 during beat 1 of 0x01020304 → out_valid=0 and busy=0 immediately (asynchronous); after release with the FIFO refilled with 0x55667788, the first byte out is 0x55.
